// File: rtl/top_pkg.sv
// Shared definitions for the March C- memory self-test: controller states
// and the per-element march descriptor (direction, read/write values).
package top_pkg;

    typedef enum logic [2:0] {
        IDLE,
        M0,
        M1,
        M2,
        M3,
        M4,
        M5,
        DONE
    } state_t;

    // One march element: address direction plus optional read and write.
    typedef struct packed {
        logic up;         // 1: address 0..N-1, 0: address N-1..0
        logic has_read;   // element reads each address first
        logic rd_val;     // expected fill value of the read (0 or 1)
        logic has_write;  // element writes each address (after the read)
        logic wr_val;     // fill value written (0 or 1)
    } march_elem_t;

    // March C-: M0 up(w0); M1 up(r0,w1); M2 up(r1,w0);
    //           M3 down(r0,w1); M4 down(r1,w0); M5 up(r0).
    function automatic march_elem_t march_elem(input state_t s);
        march_elem_t e;
        case (s)
            M0:      e = '{up: 1'b1, has_read: 1'b0, rd_val: 1'b0, has_write: 1'b1, wr_val: 1'b0};
            M1:      e = '{up: 1'b1, has_read: 1'b1, rd_val: 1'b0, has_write: 1'b1, wr_val: 1'b1};
            M2:      e = '{up: 1'b1, has_read: 1'b1, rd_val: 1'b1, has_write: 1'b1, wr_val: 1'b0};
            M3:      e = '{up: 1'b0, has_read: 1'b1, rd_val: 1'b0, has_write: 1'b1, wr_val: 1'b1};
            M4:      e = '{up: 1'b0, has_read: 1'b1, rd_val: 1'b1, has_write: 1'b1, wr_val: 1'b0};
            M5:      e = '{up: 1'b1, has_read: 1'b1, rd_val: 1'b0, has_write: 1'b0, wr_val: 1'b0};
            default: e = '{up: 1'b1, has_read: 1'b0, rd_val: 1'b0, has_write: 1'b0, wr_val: 1'b0};
        endcase
        return e;
    endfunction

    // Element sequencing; the last element hands over to DONE.
    function automatic state_t march_next(input state_t s);
        state_t n;
        case (s)
            M0:      n = M1;
            M1:      n = M2;
            M2:      n = M3;
            M3:      n = M4;
            M4:      n = M5;
            M5:      n = DONE;
            default: n = s;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bist_ram.sv
// N x data_width RAM under test: synchronous write, combinational read,
// contents not reset. Build macro TOP_FAULT_INJECT_EN makes bit 0 of
// address 0 read stuck-at-1.
module bist_ram #(
    parameter int data_width = 4,
    parameter int ad_width   = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ad_width-1:0]   addr,
    input  logic [data_width-1:0] wdata,
    output logic [data_width-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ad_width;

    logic [data_width-1:0] mem_q [DEPTH];

    // Storage write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

`ifdef TOP_FAULT_INJECT_EN
    // Read port with a stuck-at-1 cell at address 0, bit 0.
    always_comb begin
        rdata = mem_q[addr];
        if (addr == '0) begin
            rdata[0] = 1'b1;
        end
    end
`else
    // Fault-free read port.
    always_comb begin
        rdata = mem_q[addr];
    end
`endif

endmodule

// File: rtl/top.sv
// March C- memory BIST: controller, read comparator and done/fail flags
// around one bist_ram instance. Build macro TOP_FAULT_INJECT_EN (handled in
// bist_ram) plants a stuck-at-1 fault so the fail path can be exercised.
module top
    import top_pkg::*;
#(
    parameter int data_width = 4,
    parameter int ad_width   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic fail,
    output logic done
);

    localparam logic [ad_width-1:0] ADDR_MAX = '1;

    state_t                state_q;
    logic [ad_width-1:0]   addr_q;
    logic                  phase_q;   // 0: read slot, 1: write slot of a r/w pair
    logic                  mism_q;    // registered compare result of the last read
    logic                  done_q;
    logic                  fail_q;

    march_elem_t           elem;
    march_elem_t           nxt_elem;
    state_t                nxt_state;
    logic                  we;
    logic                  rd_en;
    logic                  op_last;
    logic                  addr_last;
    logic [data_width-1:0] wdata;
    logic [data_width-1:0] exp_word;
    logic [data_width-1:0] rdata;

    // Decode the current element and slot into one RAM operation.
    always_comb begin
        elem      = march_elem(state_q);
        nxt_state = march_next(state_q);
        nxt_elem  = march_elem(nxt_state);
        rd_en     = elem.has_read  && (!elem.has_write || !phase_q);
        we        = elem.has_write && (!elem.has_read  ||  phase_q);
        op_last   = !(elem.has_read && elem.has_write) || phase_q;
        addr_last = elem.up ? (addr_q == ADDR_MAX) : (addr_q == '0);
        wdata     = {data_width{elem.wr_val}};
        exp_word  = {data_width{elem.rd_val}};
    end

    bist_ram #(
        .data_width (data_width),
        .ad_width   (ad_width)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .addr  (addr_q),
        .wdata (wdata),
        .rdata (rdata)
    );

    // Controller FSM with registered compare, sticky fail and done level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            phase_q <= 1'b0;
            mism_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            mism_q <= rd_en && (rdata != exp_word);
            fail_q <= fail_q | mism_q;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= M0;
                        addr_q  <= '0;
                        phase_q <= 1'b0;
                        mism_q  <= 1'b0;
                        done_q  <= 1'b0;
                        fail_q  <= 1'b0;
                    end else if (state_q == DONE) begin
                        // Raised one edge after entry so the final M5 compare lands first.
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    if (op_last) begin
                        phase_q <= 1'b0;
                        if (addr_last) begin
                            state_q <= nxt_state;
                            addr_q  <= nxt_elem.up ? '0 : ADDR_MAX;
                        end else begin
                            addr_q  <= elem.up ? addr_q + ad_width'(1) : addr_q - ad_width'(1);
                        end
                    end else begin
                        phase_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign done = done_q;
    assign fail = fail_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the March C- BIST top. Expected done/fail timing
// comes from a behavioural walk of the March C- algorithm over an array.
module tb_top;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int NW = 1 << AW;
    localparam logic [DW-1:0] ONES  = '1;
    localparam logic [DW-1:0] ZEROS = '0;

    logic clk;
    logic rst;
    logic start;
    logic fail;
    logic done;

    int errors;
    int checks;

    top #(
        .data_width (DW),
        .ad_width   (AW)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .fail  (fail),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Walk March C- over a model memory; returns the 1-based index of the
    // first mismatching operation (0 if none) and the total operation count.
    function automatic int model_first_mismatch(output int total_ops);
        logic [DW-1:0] mem [NW];
        logic [DW-1:0] v;
        int up [6];
        int rd [6];
        int wr [6];
        int first;
        int ops;
        int a;
        up = '{1, 1, 1, 0, 0, 1};
        rd = '{-1, 0, 1, 0, 1, 0};
        wr = '{0, 1, 0, 1, 0, -1};
        first = 0;
        ops = 0;
        for (int i = 0; i < NW; i++) mem[i] = 'x;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < NW; i++) begin
                a = (up[e] != 0) ? i : NW - 1 - i;
                if (rd[e] >= 0) begin
                    ops++;
                    v = mem[a];
`ifdef TOP_FAULT_INJECT_EN
                    if (a == 0) v[0] = 1'b1;
`endif
                    if (first == 0 && v !== ((rd[e] != 0) ? ONES : ZEROS)) first = ops;
                end
                if (wr[e] >= 0) begin
                    ops++;
                    mem[a] = (wr[e] != 0) ? ONES : ZEROS;
                end
            end
        end
        total_ops = ops;
        return first;
    endfunction

    // Start a run and check done/fail after every edge until two edges past
    // completion; optionally pulse start again before edge 'extra_at'.
    task automatic check_run(input string name, input int extra_at);
        int total;
        int first;
        int done_edge;
        int fail_edge;
        logic exp_done;
        logic exp_fail;
        first     = model_first_mismatch(total);
        done_edge = total + 1;
        fail_edge = (first > 0) ? first + 1 : -1;
        @(negedge clk);
        start = 1'b1;
        for (int j = 0; j <= done_edge + 2; j++) begin
            if (j > 0 && j == extra_at) begin
                @(negedge clk);
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            exp_done = (j >= done_edge);
            exp_fail = (fail_edge > 0) && (j >= fail_edge);
            checks++;
            if (done !== exp_done) begin
                errors++;
                $display("FAIL %s done edge %0d: got %b, required %b", name, j, done, exp_done);
            end
            checks++;
            if (fail !== exp_fail) begin
                errors++;
                $display("FAIL %s fail edge %0d: got %b, required %b", name, j, fail, exp_fail);
            end
        end
    endtask

    // Idle cycles without start: flags must stay clear.
    task automatic check_idle(input string name, input int cycles);
        for (int j = 0; j < cycles; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || fail !== 1'b0) begin
                errors++;
                $display("FAIL %s idle %0d: done=%b fail=%b, required 0/0", name, j, done, fail);
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || fail !== 1'b0) begin
                errors++;
                $display("FAIL reset cycle %0d: done=%b fail=%b, required 0/0", j, done, fail);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_idle", 3);
    endtask

    task automatic test_clean_run();
        check_run("clean_run", -1);
    endtask

    task automatic test_start_while_busy();
        check_idle("busy_gap", 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_run("busy_at_50", 50);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_run("busy_at_last_op", 10 * NW);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_run("busy_random", $urandom_range(1, 10 * NW));
    endtask

    // Previous run left the DUT in DONE; start again straight from there.
    task automatic test_restart();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart precondition: done=%b, required 1", done);
        end
        check_run("restart_from_done", -1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        check_run("restart_after_gap", -1);
    endtask

    task automatic test_reset_mid_test(input int rst_at);
        int total;
        int first;
        logic exp_fail;
        first = model_first_mismatch(total);
        @(negedge clk);
        start = 1'b1;
        for (int j = 0; j <= rst_at; j++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            exp_fail = (first > 0) && (j >= first + 1);
            checks++;
            if (done !== 1'b0 || fail !== exp_fail) begin
                errors++;
                $display("FAIL mid_test pre-reset edge %0d: done=%b fail=%b, required 0/%b", j, done, fail, exp_fail);
            end
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL mid_test async reset: done=%b fail=%b, required 0/0", done, fail);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_test_idle", 4);
        check_run("after_mid_reset", -1);
    endtask

    task automatic test_reset_in_done();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_done precondition: done=%b, required 1", done);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || fail !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_done async: done=%b fail=%b, required 0/0", done, fail);
        end
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_in_done_idle", 3);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        start  = 1'b0;
        test_reset();
        test_clean_run();
        test_start_while_busy();
        test_restart();
        test_reset_mid_test(80);
        test_reset_mid_test($urandom_range(20, 10 * NW - 1));
        test_reset_in_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
